// File: rtl/alu_rsv_station_if.sv
// Dispatch, CDB and issue bundle between rename/dispatch, the ALU reservation station and the ALU.
interface alu_rsv_station_if #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned PREG_W      = 6,
  parameter int unsigned ALU_OP_SIZE = 4,
  parameter int unsigned CNT_W       = 4
);
  logic                   flush_i;
  logic                   dispatch_valid_i;
  logic                   dispatch_ready_o;
  logic [ALU_OP_SIZE-1:0] dispatch_alu_op_i;
  logic [PREG_W-1:0]      dispatch_dest_preg_i;
  logic [PREG_W-1:0]      dispatch_src0_preg_i;
  logic [PREG_W-1:0]      dispatch_src1_preg_i;
  logic                   dispatch_src0_rdy_i;
  logic                   dispatch_src1_rdy_i;
  logic [WORD_SIZE-1:0]   dispatch_src0_data_i;
  logic [WORD_SIZE-1:0]   dispatch_src1_data_i;
  logic                   cdb_valid_i;
  logic [PREG_W-1:0]      cdb_preg_i;
  logic [WORD_SIZE-1:0]   cdb_data_i;
  logic                   issue_valid_o;
  logic                   issue_ready_i;
  logic [ALU_OP_SIZE-1:0] issue_alu_op_o;
  logic [WORD_SIZE-1:0]   issue_data0_o;
  logic [WORD_SIZE-1:0]   issue_data1_o;
  logic [PREG_W-1:0]      issue_dest_preg_o;
  logic [CNT_W-1:0]       count_o;

  modport slave (
    input  flush_i, dispatch_valid_i, dispatch_alu_op_i, dispatch_dest_preg_i,
           dispatch_src0_preg_i, dispatch_src1_preg_i, dispatch_src0_rdy_i, dispatch_src1_rdy_i,
           dispatch_src0_data_i, dispatch_src1_data_i, cdb_valid_i, cdb_preg_i, cdb_data_i,
           issue_ready_i,
    output dispatch_ready_o, issue_valid_o, issue_alu_op_o, issue_data0_o, issue_data1_o,
           issue_dest_preg_o, count_o
  );

  modport master (
    output flush_i, dispatch_valid_i, dispatch_alu_op_i, dispatch_dest_preg_i,
           dispatch_src0_preg_i, dispatch_src1_preg_i, dispatch_src0_rdy_i, dispatch_src1_rdy_i,
           dispatch_src0_data_i, dispatch_src1_data_i, cdb_valid_i, cdb_preg_i, cdb_data_i,
           issue_ready_i,
    input  dispatch_ready_o, issue_valid_o, issue_alu_op_o, issue_data0_o, issue_data1_o,
           issue_dest_preg_o, count_o
  );
endinterface

// File: rtl/alu_rsv_station.sv
// ALU reservation station: buffers renamed ops, wakes operands off the CDB and
// issues the oldest ready op into a registered issue stage feeding the ALU.
module alu_rsv_station #(
  parameter int unsigned WORD_SIZE   = 32,
  parameter int unsigned NUM_P_REGS  = 64,
  parameter int unsigned PREG_W      = 6,
  parameter int unsigned ALU_OP_SIZE = 4,
  parameter int unsigned RS_DEPTH    = 8,
  parameter int unsigned CNT_W       = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  alu_rsv_station_if.slave rs
);
  localparam int unsigned IDX_W = $clog2(RS_DEPTH);

  logic [RS_DEPTH-1:0]    valid_q, rdy0_q, rdy1_q;
  logic [ALU_OP_SIZE-1:0] op_q    [RS_DEPTH];
  logic [PREG_W-1:0]      dest_q  [RS_DEPTH];
  logic [PREG_W-1:0]      tag0_q  [RS_DEPTH];
  logic [PREG_W-1:0]      tag1_q  [RS_DEPTH];
  logic [WORD_SIZE-1:0]   data0_q [RS_DEPTH];
  logic [WORD_SIZE-1:0]   data1_q [RS_DEPTH];
  // older_q[i][j] set means entry j was dispatched before entry i
  logic [RS_DEPTH-1:0]    older_q [RS_DEPTH];

  logic [CNT_W-1:0]       count_q;
  logic                   ready_q;
  logic                   issue_valid_q;
  logic [ALU_OP_SIZE-1:0] issue_op_q;
  logic [WORD_SIZE-1:0]   issue_d0_q, issue_d1_q;
  logic [PREG_W-1:0]      issue_dest_q;

  logic [RS_DEPTH-1:0]    elig_c, win_c;
  logic [IDX_W-1:0]       sel_idx_c, alloc_idx_c;
  logic                   sel_found_c, accept_c, select_c, byp0_c, byp1_c;
  logic [CNT_W-1:0]       count_next_c;

  // Oldest-eligible select, lowest-free allocate, next occupancy
  always_comb begin
    elig_c      = valid_q & rdy0_q & rdy1_q;
    win_c       = '0;
    sel_idx_c   = '0;
    alloc_idx_c = '0;
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      win_c[i] = elig_c[i] && ((elig_c & older_q[i]) == '0);
    end
    for (int i = int'(RS_DEPTH) - 1; i >= 0; i--) begin
      if (win_c[i])    sel_idx_c   = IDX_W'(i);
      if (!valid_q[i]) alloc_idx_c = IDX_W'(i);
    end
    sel_found_c  = |win_c;
    accept_c     = rs.dispatch_valid_i && ready_q;
    select_c     = (!issue_valid_q || rs.issue_ready_i) && sel_found_c;
    byp0_c       = rs.cdb_valid_i && (rs.dispatch_src0_preg_i == rs.cdb_preg_i);
    byp1_c       = rs.cdb_valid_i && (rs.dispatch_src1_preg_i == rs.cdb_preg_i);
    count_next_c = count_q + CNT_W'(accept_c) - CNT_W'(select_c);
  end

  // Control state: occupancy, readiness, age order and the issue register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q       <= '0;
      rdy0_q        <= '0;
      rdy1_q        <= '0;
      for (int i = 0; i < int'(RS_DEPTH); i++) older_q[i] <= '0;
      count_q       <= '0;
      ready_q       <= 1'b1;
      issue_valid_q <= 1'b0;
      issue_op_q    <= '0;
      issue_d0_q    <= '0;
      issue_d1_q    <= '0;
      issue_dest_q  <= '0;
    end else if (rs.flush_i) begin
      valid_q       <= '0;
      count_q       <= '0;
      ready_q       <= 1'b1;
      issue_valid_q <= 1'b0;
    end else begin
      count_q <= count_next_c;
      ready_q <= (count_next_c != CNT_W'(RS_DEPTH));
      if (select_c) begin
        valid_q[sel_idx_c] <= 1'b0;
        issue_valid_q      <= 1'b1;
        issue_op_q         <= op_q[sel_idx_c];
        issue_d0_q         <= data0_q[sel_idx_c];
        issue_d1_q         <= data1_q[sel_idx_c];
        issue_dest_q       <= dest_q[sel_idx_c];
      end else if (rs.issue_ready_i) begin
        issue_valid_q <= 1'b0;
      end
      for (int i = 0; i < int'(RS_DEPTH); i++) begin
        if (rs.cdb_valid_i && valid_q[i] && !rdy0_q[i] && tag0_q[i] == rs.cdb_preg_i) rdy0_q[i] <= 1'b1;
        if (rs.cdb_valid_i && valid_q[i] && !rdy1_q[i] && tag1_q[i] == rs.cdb_preg_i) rdy1_q[i] <= 1'b1;
      end
      if (accept_c) begin
        valid_q[alloc_idx_c] <= 1'b1;
        rdy0_q[alloc_idx_c]  <= rs.dispatch_src0_rdy_i || byp0_c;
        rdy1_q[alloc_idx_c]  <= rs.dispatch_src1_rdy_i || byp1_c;
        for (int j = 0; j < int'(RS_DEPTH); j++) older_q[j][alloc_idx_c] <= 1'b0;
        older_q[alloc_idx_c] <= valid_q;
      end
    end
  end

  // Entry payload; only meaningful while the matching valid bit is set
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(RS_DEPTH); i++) begin
      if (rs.cdb_valid_i && valid_q[i] && !rdy0_q[i] && tag0_q[i] == rs.cdb_preg_i) data0_q[i] <= rs.cdb_data_i;
      if (rs.cdb_valid_i && valid_q[i] && !rdy1_q[i] && tag1_q[i] == rs.cdb_preg_i) data1_q[i] <= rs.cdb_data_i;
    end
    if (accept_c && !rs.flush_i) begin
      op_q[alloc_idx_c]    <= rs.dispatch_alu_op_i;
      dest_q[alloc_idx_c]  <= rs.dispatch_dest_preg_i;
      tag0_q[alloc_idx_c]  <= rs.dispatch_src0_preg_i;
      tag1_q[alloc_idx_c]  <= rs.dispatch_src1_preg_i;
      data0_q[alloc_idx_c] <= rs.dispatch_src0_rdy_i ? rs.dispatch_src0_data_i : rs.cdb_data_i;
      data1_q[alloc_idx_c] <= rs.dispatch_src1_rdy_i ? rs.dispatch_src1_data_i : rs.cdb_data_i;
    end
  end

  assign rs.dispatch_ready_o  = ready_q;
  assign rs.count_o           = count_q;
  assign rs.issue_valid_o     = issue_valid_q;
  assign rs.issue_alu_op_o    = issue_op_q;
  assign rs.issue_data0_o     = issue_d0_q;
  assign rs.issue_data1_o     = issue_d1_q;
  assign rs.issue_dest_preg_o = issue_dest_q;
endmodule

// File: tb/tb_alu_rsv_station.sv
// Directed plus random bench for alu_rsv_station against a dispatch-ordered queue model.
module tb_alu_rsv_station;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_rsv_station_if #(.WORD_SIZE(32), .PREG_W(6), .ALU_OP_SIZE(4), .CNT_W(4)) bus ();

  alu_rsv_station #(
    .WORD_SIZE(32), .NUM_P_REGS(64), .PREG_W(6), .ALU_OP_SIZE(4), .RS_DEPTH(8), .CNT_W(4)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .rs      (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  dest, t0, t1;
    bit          r0, r1;
    logic [31:0] d0, d1;
  } ent_t;

  ent_t        mq[$];
  bit          m_iv;
  logic [3:0]  m_op;
  logic [31:0] m_d0, m_d1;
  logic [5:0]  m_dest;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.flush_i = 1'b0;
    bus.dispatch_valid_i = 1'b0;
    bus.dispatch_alu_op_i = '0;
    bus.dispatch_dest_preg_i = '0;
    bus.dispatch_src0_preg_i = '0;
    bus.dispatch_src1_preg_i = '0;
    bus.dispatch_src0_rdy_i = 1'b0;
    bus.dispatch_src1_rdy_i = 1'b0;
    bus.dispatch_src0_data_i = '0;
    bus.dispatch_src1_data_i = '0;
    bus.cdb_valid_i = 1'b0;
    bus.cdb_preg_i = '0;
    bus.cdb_data_i = '0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [5:0] dest,
                      input logic [5:0] t0, input bit r0, input logic [31:0] d0,
                      input logic [5:0] t1, input bit r1, input logic [31:0] d1);
    bus.dispatch_valid_i = 1'b1;
    bus.dispatch_alu_op_i = op;
    bus.dispatch_dest_preg_i = dest;
    bus.dispatch_src0_preg_i = t0;
    bus.dispatch_src0_rdy_i = r0;
    bus.dispatch_src0_data_i = d0;
    bus.dispatch_src1_preg_i = t1;
    bus.dispatch_src1_rdy_i = r1;
    bus.dispatch_src1_data_i = d1;
  endtask

  task automatic cdb(input bit v, input logic [5:0] tag, input logic [31:0] data);
    bus.cdb_valid_i = v;
    bus.cdb_preg_i = tag;
    bus.cdb_data_i = data;
  endtask

  task automatic model_reset();
    mq.delete();
    m_iv = 1'b0;
    m_op = '0; m_d0 = '0; m_d1 = '0; m_dest = '0;
  endtask

  // One clock edge of the station, evaluated from the rules on the input values at the edge
  task automatic model_edge();
    bit   acc;
    int   idx;
    ent_t e;
    if (bus.flush_i) begin
      mq.delete();
      m_iv = 1'b0;
      return;
    end
    acc = bus.dispatch_valid_i && (mq.size() != 8);
    idx = -1;
    foreach (mq[i]) if (idx < 0 && mq[i].r0 && mq[i].r1) idx = i;
    if ((!m_iv || bus.issue_ready_i) && idx >= 0) begin
      m_iv = 1'b1;
      m_op = mq[idx].op; m_d0 = mq[idx].d0; m_d1 = mq[idx].d1; m_dest = mq[idx].dest;
      mq.delete(idx);
    end else if (bus.issue_ready_i) begin
      m_iv = 1'b0;
    end
    if (bus.cdb_valid_i) begin
      foreach (mq[i]) begin
        if (!mq[i].r0 && mq[i].t0 == bus.cdb_preg_i) begin mq[i].r0 = 1'b1; mq[i].d0 = bus.cdb_data_i; end
        if (!mq[i].r1 && mq[i].t1 == bus.cdb_preg_i) begin mq[i].r1 = 1'b1; mq[i].d1 = bus.cdb_data_i; end
      end
    end
    if (acc) begin
      e.op = bus.dispatch_alu_op_i; e.dest = bus.dispatch_dest_preg_i;
      e.t0 = bus.dispatch_src0_preg_i; e.t1 = bus.dispatch_src1_preg_i;
      e.r0 = bus.dispatch_src0_rdy_i || (bus.cdb_valid_i && e.t0 == bus.cdb_preg_i);
      e.r1 = bus.dispatch_src1_rdy_i || (bus.cdb_valid_i && e.t1 == bus.cdb_preg_i);
      e.d0 = bus.dispatch_src0_rdy_i ? bus.dispatch_src0_data_i : bus.cdb_data_i;
      e.d1 = bus.dispatch_src1_rdy_i ? bus.dispatch_src1_data_i : bus.cdb_data_i;
      mq.push_back(e);
    end
  endtask

  task automatic compare();
    chk("count", 32'(bus.count_o), 32'(mq.size()));
    chk("dispatch_ready", 32'(bus.dispatch_ready_o), 32'(mq.size() != 8));
    chk("issue_valid", 32'(bus.issue_valid_o), 32'(m_iv));
    if (m_iv) begin
      chk("issue_op", 32'(bus.issue_alu_op_o), 32'(m_op));
      chk("issue_data0", bus.issue_data0_o, m_d0);
      chk("issue_data1", bus.issue_data1_o, m_d1);
      chk("issue_dest", 32'(bus.issue_dest_preg_o), 32'(m_dest));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_count"}, 32'(bus.count_o), 32'd0);
    chk({tag, "_ivalid"}, 32'(bus.issue_valid_o), 32'd0);
    chk({tag, "_op"}, 32'(bus.issue_alu_op_o), 32'd0);
    chk({tag, "_d0"}, bus.issue_data0_o, 32'd0);
    chk({tag, "_d1"}, bus.issue_data1_o, 32'd0);
    chk({tag, "_dest"}, 32'(bus.issue_dest_preg_o), 32'd0);
  endtask

  initial begin
    idle();
    bus.issue_ready_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    cycle();

    // Both sources ready: issue visible two cycles after the handshake
    disp(4'b0010, 6'd12, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
    cycle();
    idle();
    chk("minlat_not_yet", 32'(bus.issue_valid_o), 32'd0);
    cycle();
    chk("minlat_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("minlat_d0", bus.issue_data0_o, 32'd5);
    chk("minlat_d1", bus.issue_data1_o, 32'd7);
    chk("minlat_dest", 32'(bus.issue_dest_preg_o), 32'd12);
    chk("minlat_op", 32'(bus.issue_alu_op_o), 32'b0010);
    chk("minlat_count", 32'(bus.count_o), 32'd0);
    cycle();

    // Wakeup from CDB after three idle cycles
    disp(4'h3, 6'd1, 6'd3, 1'b1, 32'h11, 6'd20, 1'b0, 32'h0);
    cycle();
    idle();
    cycles(3);
    cdb(1'b1, 6'd20, 32'hDEADBEEF);
    cycle();
    idle();
    chk("wake_not_before", 32'(bus.issue_valid_o), 32'd0);
    cycle();
    chk("wake_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("wake_d1", bus.issue_data1_o, 32'hDEADBEEF);
    cycle();

    // Dispatch/CDB bypass in the same cycle
    disp(4'h5, 6'd4, 6'd9, 1'b0, 32'h0, 6'd8, 1'b1, 32'h22);
    cdb(1'b1, 6'd9, 32'd3);
    cycle();
    idle();
    cycle();
    chk("bypass_valid", 32'(bus.issue_valid_o), 32'd1);
    chk("bypass_d0", bus.issue_data0_o, 32'd3);
    cycle();

    // Fill all eight entries waiting on tag 30, then release them in order
    for (int k = 0; k < 8; k++) begin
      disp(4'(k), 6'(40 + k), 6'd30, 1'b0, 32'h0, 6'd0, 1'b1, 32'(100 + k));
      cycle();
    end
    disp(4'hF, 6'd63, 6'd1, 1'b1, 32'h1, 6'd1, 1'b1, 32'h1);
    cycle();
    idle();
    chk("full_count", 32'(bus.count_o), 32'd8);
    chk("full_ready", 32'(bus.dispatch_ready_o), 32'd0);
    cdb(1'b1, 6'd30, 32'hCAFE0030);
    cycle();
    idle();
    cycles(12);

    // Hold issue with three ready entries
    bus.issue_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp(4'(8 + k), 6'(50 + k), 6'd0, 1'b1, 32'(200 + k), 6'd0, 1'b1, 32'(300 + k));
      cycle();
    end
    idle();
    cycles(4);
    chk("hold_count", 32'(bus.count_o), 32'd2);
    bus.issue_ready_i = 1'b1;
    cycles(5);

    // Flush with five entries and a held issue op, dispatch in the flush cycle
    bus.issue_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      disp(4'(k), 6'(10 + k), 6'd0, 1'b1, 32'(k), 6'd0, 1'b1, 32'(k));
      cycle();
    end
    idle();
    cycle();
    disp(4'hA, 6'd33, 6'd0, 1'b1, 32'h1, 6'd0, 1'b1, 32'h2);
    bus.flush_i = 1'b1;
    cycle();
    idle();
    chk("flush_count", 32'(bus.count_o), 32'd0);
    chk("flush_ivalid", 32'(bus.issue_valid_o), 32'd0);
    bus.issue_ready_i = 1'b1;
    cycles(4);

    // Asynchronous reset mid-stream
    for (int k = 0; k < 4; k++) begin
      disp(4'(k), 6'(20 + k), 6'd5, k[0], 32'(k), 6'd0, 1'b1, 32'(k));
      cycle();
    end
    idle();
    #2 rst_n = 1'b0;
    #1 check_cleared("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      idle();
      bus.flush_i = ($urandom_range(0, 59) == 0);
      bus.issue_ready_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 9) < 6)
        disp(4'($urandom), 6'($urandom), 6'($urandom_range(0, 7)), 1'($urandom), $urandom,
             6'($urandom_range(0, 7)), 1'($urandom), $urandom);
      if ($urandom_range(0, 9) < 4)
        cdb(1'b1, 6'($urandom_range(0, 7)), $urandom);
      cycle();
    end
    idle();
    bus.issue_ready_i = 1'b1;
    cycles(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
